// File: rtl/decode_stage.sv
// Instruction decode stage: combinational field split and ALU decode feeding a
// registered output stage backed by a one-deep skid register.

package decode_pkg;
  localparam logic [1:0] ALU_OP__UNSET              = 2'd0;
  localparam logic [1:0] ALU_OP__ADD                = 2'd1;
  localparam logic [1:0] ALU_OP__BRANCH             = 2'd2;
  localparam logic [1:0] ALU_OP__REGISTER_OPERATION = 2'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_NOP  = 4'd15;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_J      = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
endpackage

module ALUdecoder
  import decode_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_control
);
  logic alt;

  // Only the exact 0100000 encoding selects SUB/SRA; anything else is the base op.
  assign alt = (funct7 == 7'b0100000);

  always_comb begin
    alu_control = ALU_NOP;
    case (alu_op)
      ALU_OP__ADD: alu_control = ALU_ADD;
      ALU_OP__BRANCH: begin
        case (funct3[2:1])
          2'b00:   alu_control = ALU_SUB;
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_NOP;
        endcase
      end
      ALU_OP__REGISTER_OPERATION: begin
        case (funct3)
          3'b000:  alu_control = alt ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_NOP;
    endcase
  end
endmodule

// state   | meaning
// S_EMPTY | nothing buffered, out_valid=0
// S_ONE   | OUT holds a bundle, SKID empty
// S_FULL  | OUT and SKID both hold bundles, in_ready=0
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter bit CHECK_ILLEGAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm_ext,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm_ext;
    logic [3:0]      alu_control;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm32;
  logic [1:0]  dec_alu_op;
  logic        dec_bad_op;
  logic        dec_illegal;
  logic [3:0]  dec_alu_control;
  bundle_t     dec;

  state_t  state;
  bundle_t out_q;
  bundle_t skid_q;
  logic    accept;
  logic    xfer;

  always_comb begin
    dec_funct3 = 3'd0;
    dec_funct7 = 7'd0;
    dec_rd     = 5'd0;
    dec_rs1    = 5'd0;
    dec_rs2    = 5'd0;
    dec_imm32  = 32'd0;
    dec_alu_op = ALU_OP__UNSET;
    dec_bad_op = 1'b0;
    case (instr[6:0])
      OP_R: begin
        dec_funct3 = instr[14:12];
        dec_funct7 = instr[31:25];
        dec_rd     = instr[11:7];
        dec_rs1    = instr[19:15];
        dec_rs2    = instr[24:20];
        dec_alu_op = ALU_OP__REGISTER_OPERATION;
      end
      OP_I: begin
        dec_funct3 = instr[14:12];
        // funct7 only matters for shifts; keeps addi with a negative imm from reading as sub
        if (instr[13:12] == 2'b01) dec_funct7 = instr[31:25];
        dec_rd     = instr[11:7];
        dec_rs1    = instr[19:15];
        dec_imm32  = {{20{instr[31]}}, instr[31:20]};
        dec_alu_op = ALU_OP__REGISTER_OPERATION;
      end
      OP_LOAD, OP_JALR: begin
        dec_funct3 = instr[14:12];
        dec_rd     = instr[11:7];
        dec_rs1    = instr[19:15];
        dec_imm32  = {{20{instr[31]}}, instr[31:20]};
        dec_alu_op = ALU_OP__ADD;
      end
      OP_S: begin
        dec_funct3 = instr[14:12];
        dec_rs1    = instr[19:15];
        dec_rs2    = instr[24:20];
        dec_imm32  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_alu_op = ALU_OP__ADD;
      end
      OP_B: begin
        dec_funct3 = instr[14:12];
        dec_rs1    = instr[19:15];
        dec_rs2    = instr[24:20];
        dec_imm32  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_alu_op = ALU_OP__BRANCH;
      end
      OP_J: begin
        dec_rd    = instr[11:7];
        dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OP_AUIPC, OP_LUI: begin
        dec_rd     = instr[11:7];
        dec_imm32  = {instr[31:12], 12'd0};
        dec_alu_op = ALU_OP__ADD;
      end
      OP_FENCE, OP_SYSTEM: dec_bad_op = 1'b0;
      default: dec_bad_op = 1'b1;
    endcase
  end

  assign dec_illegal = CHECK_ILLEGAL & (dec_bad_op | (instr[1:0] != 2'b11));

  ALUdecoder u_alu_decoder (
    .alu_op      (dec_alu_op),
    .funct3      (dec_funct3),
    .funct7      (dec_funct7),
    .alu_control (dec_alu_control)
  );

  always_comb begin
    dec             = '0;
    dec.opcode      = instr[6:0];
    dec.funct3      = dec_funct3;
    dec.funct7      = dec_funct7;
    dec.rd          = dec_rd;
    dec.rs1         = dec_rs1;
    dec.rs2         = dec_rs2;
    dec.imm_ext     = XLEN'(signed'(dec_imm32));
    dec.alu_control = dec_alu_control;
    dec.pc          = pc_in;
    dec.illegal     = dec_illegal;
  end

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            out_q     <= dec;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (xfer) begin
            if (accept) begin
              out_q <= dec;
            end else begin
              out_valid <= 1'b0;
              state     <= S_EMPTY;
            end
          end else if (accept) begin
            skid_q   <= dec;
            in_ready <= 1'b0;
            state    <= S_FULL;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no new input can arrive alongside the drain
          if (xfer) begin
            out_q    <= skid_q;
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign opcode      = out_q.opcode;
  assign funct3      = out_q.funct3;
  assign funct7      = out_q.funct7;
  assign rd          = out_q.rd;
  assign rs1         = out_q.rs1;
  assign rs2         = out_q.rs2;
  assign imm_ext     = out_q.imm_ext;
  assign alu_control = out_q.alu_control;
  assign pc_out      = out_q.pc;
  assign illegal     = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one default instance plus XLEN=64 and
// CHECK_ILLEGAL=0 instances driven by the same stimulus.

module tb_decode_stage;

  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SW   = 32'h0021A423;
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LUI  = 32'h800002B7;
  localparam logic [31:0] I_ZERO = 32'h00000000;
  localparam logic [31:0] I_ONES = 32'hFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush, in_valid, out_ready;
  logic [31:0] instr, pc32;
  logic [63:0] pc64;

  logic        in_ready, out_valid, illegal;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_ext, pc_out;
  logic [3:0]  alu_control;

  logic        in_ready_w, out_valid_w, illegal_w;
  logic [6:0]  opcode_w, funct7_w;
  logic [2:0]  funct3_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;
  logic [63:0] imm_ext_w, pc_out_w;
  logic [3:0]  alu_control_w;

  logic        in_ready_n, out_valid_n, illegal_n;
  logic [6:0]  opcode_n, funct7_n;
  logic [2:0]  funct3_n;
  logic [4:0]  rd_n, rs1_n, rs2_n;
  logic [31:0] imm_ext_n, pc_out_n;
  logic [3:0]  alu_control_n;

  assign pc64 = {32'h0, pc32};

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc32), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm_ext(imm_ext), .alu_control(alu_control), .pc_out(pc_out), .illegal(illegal)
  );

  decode_stage #(.XLEN(64)) dut_wide (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .instr(instr), .pc_in(pc64), .out_valid(out_valid_w), .out_ready(out_ready),
    .opcode(opcode_w), .funct3(funct3_w), .funct7(funct7_w), .rd(rd_w), .rs1(rs1_w), .rs2(rs2_w),
    .imm_ext(imm_ext_w), .alu_control(alu_control_w), .pc_out(pc_out_w), .illegal(illegal_w)
  );

  decode_stage #(.CHECK_ILLEGAL(1'b0)) dut_nochk (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .instr(instr), .pc_in(pc32), .out_valid(out_valid_n), .out_ready(out_ready),
    .opcode(opcode_n), .funct3(funct3_n), .funct7(funct7_n), .rd(rd_n), .rs1(rs1_n), .rs2(rs2_n),
    .imm_ext(imm_ext_n), .alu_control(alu_control_n), .pc_out(pc_out_n), .illegal(illegal_n)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    instr    = ins;
    pc32     = pc;
  endtask

  task automatic chk_zero_payload(input string tag);
    chk({tag, ".opcode"}, 64'(opcode), 64'h0);
    chk({tag, ".funct3"}, 64'(funct3), 64'h0);
    chk({tag, ".funct7"}, 64'(funct7), 64'h0);
    chk({tag, ".rd"}, 64'(rd), 64'h0);
    chk({tag, ".rs1"}, 64'(rs1), 64'h0);
    chk({tag, ".rs2"}, 64'(rs2), 64'h0);
    chk({tag, ".imm"}, 64'(imm_ext), 64'h0);
    chk({tag, ".alu"}, 64'(alu_control), 64'h0);
    chk({tag, ".pc"}, 64'(pc_out), 64'h0);
    chk({tag, ".illegal"}, 64'(illegal), 64'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("rst_hold.out_valid", 64'(out_valid), 64'h0);
    chk("rst_hold.in_ready", 64'(in_ready), 64'h1);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'h0);
    chk("rst.in_ready", 64'(in_ready), 64'h1);
    chk("rst.wide_imm", imm_ext_w, 64'h0);
    chk_zero_payload("rst");

    // streaming with out_ready high: one bundle per cycle, one cycle behind input
    drive(1'b1, I_ADDI, 32'h1000);
    @(negedge clk);
    chk("addi.out_valid", 64'(out_valid), 64'h1);
    chk("addi.in_ready", 64'(in_ready), 64'h1);
    chk("addi.pc", 64'(pc_out), 64'h1000);
    chk("addi.opcode", 64'(opcode), 64'h13);
    chk("addi.imm", 64'(imm_ext), 64'hFFFF_FFFF);
    chk("addi.funct7", 64'(funct7), 64'h0);
    chk("addi.rd", 64'(rd), 64'h1);
    chk("addi.alu", 64'(alu_control), 64'h0);
    chk("addi.illegal", 64'(illegal), 64'h0);
    chk("addi.wide_imm", imm_ext_w, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b1, I_SW, 32'h1004);
    @(negedge clk);
    chk("sw.out_valid", 64'(out_valid), 64'h1);
    chk("sw.pc", 64'(pc_out), 64'h1004);
    chk("sw.imm", 64'(imm_ext), 64'h8);
    chk("sw.rd", 64'(rd), 64'h0);
    chk("sw.rs1", 64'(rs1), 64'h3);
    chk("sw.rs2", 64'(rs2), 64'h2);
    chk("sw.funct3", 64'(funct3), 64'h2);
    chk("sw.alu", 64'(alu_control), 64'h0);
    drive(1'b1, I_BEQ, 32'h1008);
    @(negedge clk);
    chk("beq.pc", 64'(pc_out), 64'h1008);
    chk("beq.imm", 64'(imm_ext), 64'hFFFF_FFFC);
    chk("beq.alu", 64'(alu_control), 64'h1);
    chk("beq.rd", 64'(rd), 64'h0);
    drive(1'b1, I_SUB, 32'h100C);
    @(negedge clk);
    chk("sub.pc", 64'(pc_out), 64'h100C);
    chk("sub.funct7", 64'(funct7), 64'h20);
    chk("sub.alu", 64'(alu_control), 64'h1);
    chk("sub.rd", 64'(rd), 64'h3);
    chk("sub.rs1", 64'(rs1), 64'h1);
    chk("sub.rs2", 64'(rs2), 64'h2);
    chk("sub.imm", 64'(imm_ext), 64'h0);
    drive(1'b1, I_LUI, 32'h1010);
    @(negedge clk);
    chk("lui.imm32", 64'(imm_ext), 64'h8000_0000);
    chk("lui.wide_imm", imm_ext_w, 64'hFFFF_FFFF_8000_0000);
    chk("lui.wide_rd", 64'(rd_w), 64'h5);
    chk("lui.wide_pc", pc_out_w, 64'h1010);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("drain.out_valid", 64'(out_valid), 64'h0);

    // backpressure: three offered while stalled, third must wait for SKID to drain
    out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h0100);
    @(negedge clk);
    chk("bp1.out_valid", 64'(out_valid), 64'h1);
    chk("bp1.in_ready", 64'(in_ready), 64'h1);
    chk("bp1.pc", 64'(pc_out), 64'h0100);
    drive(1'b1, I_SW, 32'h0104);
    @(negedge clk);
    chk("bp2.in_ready", 64'(in_ready), 64'h0);
    chk("bp2.pc", 64'(pc_out), 64'h0100);
    chk("bp2.imm", 64'(imm_ext), 64'hFFFF_FFFF);
    drive(1'b1, I_BEQ, 32'h0108);
    @(negedge clk);
    chk("bp3.in_ready", 64'(in_ready), 64'h0);
    chk("bp3.pc", 64'(pc_out), 64'h0100);
    chk("bp3.out_valid", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel1.pc", 64'(pc_out), 64'h0104);
    chk("bp_rel1.imm", 64'(imm_ext), 64'h8);
    chk("bp_rel1.in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    chk("bp_rel2.pc", 64'(pc_out), 64'h0108);
    chk("bp_rel2.imm", 64'(imm_ext), 64'hFFFF_FFFC);
    chk("bp_rel2.out_valid", 64'(out_valid), 64'h1);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("bp_end.out_valid", 64'(out_valid), 64'h0);

    // flush while FULL with a new instruction offered
    out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h0200);
    @(negedge clk);
    drive(1'b1, I_SW, 32'h0204);
    @(negedge clk);
    chk("fl_full.in_ready", 64'(in_ready), 64'h0);
    flush = 1'b1;
    drive(1'b1, I_BEQ, 32'h0208);
    @(negedge clk);
    chk("fl.out_valid", 64'(out_valid), 64'h0);
    chk("fl.in_ready", 64'(in_ready), 64'h1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("fl_after.out_valid", 64'(out_valid), 64'h0);
    end

    // flush with in_valid in an empty stage accepts nothing
    flush = 1'b1;
    drive(1'b1, I_ADDI, 32'h0300);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_empty.out_valid", 64'(out_valid), 64'h0);

    // illegal encodings
    drive(1'b1, I_ZERO, 32'h0400);
    @(negedge clk);
    chk("ill0.illegal", 64'(illegal), 64'h1);
    chk("ill0.rd", 64'(rd), 64'h0);
    chk("ill0.imm", 64'(imm_ext), 64'h0);
    chk("ill0.nochk", 64'(illegal_n), 64'h0);
    chk("ill0.pc", 64'(pc_out), 64'h0400);
    drive(1'b1, I_ONES, 32'h0404);
    @(negedge clk);
    chk("ill7f.illegal", 64'(illegal), 64'h1);
    chk("ill7f.opcode", 64'(opcode), 64'h7F);
    chk("ill7f.rd", 64'(rd), 64'h0);
    chk("ill7f.rs1", 64'(rs1), 64'h0);
    chk("ill7f.rs2", 64'(rs2), 64'h0);
    chk("ill7f.imm", 64'(imm_ext), 64'h0);
    chk("ill7f.nochk", 64'(illegal_n), 64'h0);
    chk("ill7f.nochk_valid", 64'(out_valid_n), 64'h1);

    // asynchronous reset while holding a bundle
    drive(1'b1, I_SW, 32'h0500);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    chk("arst_pre.out_valid", 64'(out_valid), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'h0);
    chk("arst.in_ready", 64'(in_ready), 64'h1);
    chk("arst.pc", 64'(pc_out), 64'h0);
    chk("arst.rs1", 64'(rs1), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_after.out_valid", 64'(out_valid), 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined, parametrised instruction-decode stage sitting between the fetch stage and the execute stage. It accepts one 32-bit instruction plus its PC per cycle over a valid/ready handshake, splits the instruction into fields, and drives the decoded bundle from a registered output. A two-entry skid buffer keeps `in_ready` registered, and the block adds flush, illegal-instruction flagging and XLEN-wide immediates.

## Interface
- `XLEN`, 32: datapath width of `imm_ext`, `pc_in` and `pc_out`. Legal values are 32 and 64.
- `CHECK_ILLEGAL`, 1: 1 enables illegal-opcode detection. 0 ties `illegal` to 0.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all buffered instructions.
- `in_valid`  in  1  `instr`/`pc_in` are valid.
- `in_ready`  out  1  stage can accept an instruction (registered).
- `instr`  in  32  raw instruction.
- `pc_in`  in  XLEN  PC of `instr`.
- `out_valid`  out  1  decoded bundle is valid.
- `out_ready`  in  1  downstream accepts the bundle.
- `opcode`  out  7  `instr[6:0]`.
- `funct3`  out  3  see Operation.
- `funct7`  out  7  see Operation.
- `rd`, `rs1`, `rs2`  out  5 each  register indices (0 when unused).
- `imm_ext`  out  XLEN  sign-extended immediate.
- `alu_control`  out  4  output of the existing `ALUdecoder`, registered.
- `pc_out`  out  XLEN  PC of the bundle.
- `illegal`  out  1  the bundle is an unsupported or illegal encoding.

## Operation
- **Front end (combinational decode of `instr`).**
  - `funct3` is `instr[14:12]` for R, I (logic, load, jalr), S and B types. It is 0 otherwise.
  - `funct7` is `instr[31:25]` for RType, and for IType_logic only when funct3 is 001 or 101 (shifts). It is 0 otherwise, so `addi` with a negative immediate never decodes as a subtract.
  - `rd`, `rs1` and `rs2` follow the instruction format. Unused fields are 0. FENCE/SYSTEM: `rd`=`rs1`=`rs2`=0.
  - `imm_ext` by format:
    - I: sign-extend `instr[31:20]`.
    - S: sign-extend {`instr[31:25]`, `instr[11:7]`}.
    - B: sign-extend {`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 0}.
    - J: sign-extend {`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 0}.
    - U: {`instr[31:12]`, 12'b0}, sign-extended to XLEN.
    - Any other opcode: 0. No latches.
  - `alu_op` mapping:
    - RType and IType_logic: ALU_OP__REGISTER_OPERATION.
    - load, jalr, S, auipc, lui: ALU_OP__ADD.
    - B: ALU_OP__BRANCH.
    - Else: ALU_OP__UNSET.
    - `alu_op`, `funct3` and `funct7` feed one `ALUdecoder` instance.
  - `illegal` (when `CHECK_ILLEGAL`=1) is set when `instr[1:0]` != 2'b11, or when the opcode is not one of RType, IType_logic, IType_load, IType_jalr, SType, BType, JType, UType_auipc, UType_lui, FENCE, SYSTEM (1110011). An illegal instruction still flows through with `illegal`=1, all register fields 0 and `imm_ext`=0.
- **Buffering.** The stage holds an output register (OUT) and a skid register (SKID), each with its own valid bit.
- **Handshake.** Accept when `in_valid & in_ready`. Transfer when `out_valid & out_ready`.
- **State update priority (highest first):**
  1. `flush`: clear both valid bits. Any input accepted in the same cycle is discarded.
  2. OUT empty or transferring: OUT loads SKID if SKID is valid, otherwise the accepted input. If SKID moved into OUT, an input accepted in the same cycle goes to SKID.
  3. OUT full and stalled, input accepted: the input goes to SKID.
- **States:**
  - EMPTY (none valid).
  - ONE (OUT valid).
  - FULL (OUT and SKID valid).
  - `in_ready` = !SKID.valid.
- **Stall rule.** Payload outputs hold stable while `out_valid & !out_ready`.

## Timing
- **Reset.** While `reset_n`=0, and immediately on assertion:
  - `out_valid`=0, `in_ready`=1.
  - `opcode`, `funct3`, `funct7`, `rd`, `rs1`, `rs2`, `imm_ext`, `alu_control`, `pc_out`, `illegal` all 0.
  - Reset mid-transfer drops all buffered instructions.
- **Latency.** 1 cycle: accepted in cycle N means `out_valid` in cycle N+1. Throughput is 1 per cycle with `out_ready` held high.
- **Stall.** A stall of ≥2 cycles with continuous `in_valid` fills SKID. `in_ready` falls in the cycle after the SKID load. It rises in the cycle after the transfer that drains SKID.
- **Flush.** `flush` in cycle N gives `out_valid`=0 and `in_ready`=1 in cycle N+1. `flush` together with `in_valid` accepts nothing.
- **Ordering.** Instructions leave in acceptance order. No bubbles are inserted while input is available and `out_ready`=1.

## Test plan
- **Reset values.** Reset, then release with `in_valid`=0 -> `out_valid`=0, `in_ready`=1, all payload outputs 0.
- **Streaming decode.** Stream `addi x1,x0,-1` (0xFFF00093), `sw x2,8(x3)` (0x0021A423) and `beq x0,x0,-4` (0xFE000EE3) with `out_ready`=1 -> one bundle per cycle, 1-cycle latency. Required fields:
  - addi: `imm_ext`=all-ones, `funct7`=0, `rd`=1.
  - sw: `imm_ext`=8, `rd`=0, `rs1`=3, `rs2`=2.
  - beq: `imm_ext`=-4.
- **XLEN=64.** `lui x5,0x80000` (0x800002B7) -> `imm_ext`=0xFFFFFFFF80000000, `rd`=5.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while streaming 3 instructions -> `in_ready` falls after the 2nd is accepted, the 3rd is not accepted, and OUT holds the 1st stable. On release, the bundles leave in order 1, 2, 3.
- **Flush.** `flush` with the stage FULL and `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1, and the flushed instructions never appear.
- **Illegal encodings.** 0x00000000 and opcode 0x7F -> `illegal`=1, register fields 0. With `CHECK_ILLEGAL`=0, `illegal` stays 0.
